// File: rtl/comb_pulse_pkg.sv
// Shared types and defaults for the comb pulse generator.
// State encoding and default parameter values.
package comb_pulse_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GAP   = 3'd1;
  localparam logic [2:0] ST_ARM   = 3'd2;
  localparam logic [2:0] ST_PULSE = 3'd3;
  localparam logic [2:0] ST_LEAVE = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    GAP   = ST_GAP,
    ARM   = ST_ARM,
    PULSE = ST_PULSE,
    LEAVE = ST_LEAVE
  } state_t;

  localparam int DEF_CNT_W      = 16;
  localparam int DEF_NUM_W      = 8;
  localparam int DEF_PRE_CYCLES = 1;

endpackage

// File: rtl/comb_pulse_timer.sv
// Loadable down-counter shared by the GAP, ARM and PULSE phases.
// Counts down to 1 and reports expiry while holding at 1.
module comb_pulse_timer
  import comb_pulse_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] value,
  output logic             expire
);

  // Load has priority; otherwise step down while enabled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (en && (value > CNT_W'(1))) begin
      value <= value - CNT_W'(1);
    end
  end

  assign expire = (value == CNT_W'(1));

endmodule

// File: rtl/comb_pulse_gen.sv
// Burst pulse generator: gap, pre-pulse warning, pulse, leave.
// FSM and pulse index live here; phase timing uses one timer.
module comb_pulse_gen
  import comb_pulse_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int NUM_W      = DEF_NUM_W,
  parameter int PRE_CYCLES = DEF_PRE_CYCLES
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             mode_cont,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [NUM_W-1:0] cfg_count,
  output logic             busy,
  output logic             about_to_pulse,
  output logic             comb_pulse,
  output logic             leaving,
  output logic             done,
  output logic [NUM_W-1:0] pulse_idx
);

  localparam logic [CNT_W-1:0] PRE_V = CNT_W'(PRE_CYCLES);

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] gap_s;
  logic [CNT_W-1:0] width_s;
  logic [NUM_W-1:0] count_s;
  logic             cont_s;
  logic             stop_pend;
  logic             pend_set;
  logic             accept;
  logic             idx_inc;
  logic             done_d;
  logic             last;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_ld_val;
  logic             tmr_en;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_expire;
  logic             unused_tmr;

  // Low time before ARM once the warning window is carved out.
  function automatic logic [CNT_W-1:0] gap_len(
    input logic [CNT_W-1:0] g
  );
    return (g > PRE_V) ? (g - PRE_V) : '0;
  endfunction

  function automatic logic [CNT_W-1:0] width_len(
    input logic [CNT_W-1:0] w
  );
    return (w == '0) ? CNT_W'(1) : w;
  endfunction

  comb_pulse_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmr_load),
    .load_val (tmr_ld_val),
    .en       (tmr_en),
    .value    (tmr_value),
    .expire   (tmr_expire)
  );

  assign unused_tmr = ^tmr_value;

  assign tmr_en = (state == GAP) ||
                  (state == ARM) ||
                  (state == PULSE);

  assign last = !cont_s &&
                ((pulse_idx + NUM_W'(1)) == count_s);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state, timer loads and event strobes.
  always_comb begin
    state_d    = state;
    tmr_load   = 1'b0;
    tmr_ld_val = '0;
    done_d     = 1'b0;
    accept     = 1'b0;
    idx_inc    = 1'b0;
    pend_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (!mode_cont && (cfg_count == '0)) begin
            done_d = 1'b1;
          end else if (gap_len(cfg_gap) == '0) begin
            state_d    = ARM;
            tmr_load   = 1'b1;
            tmr_ld_val = PRE_V;
          end else begin
            state_d    = GAP;
            tmr_load   = 1'b1;
            tmr_ld_val = gap_len(cfg_gap);
          end
        end
      end
      GAP: begin
        if (stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (tmr_expire) begin
          state_d    = ARM;
          tmr_load   = 1'b1;
          tmr_ld_val = PRE_V;
        end
      end
      ARM: begin
        if (stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (tmr_expire) begin
          state_d    = PULSE;
          tmr_load   = 1'b1;
          tmr_ld_val = width_len(width_s);
        end
      end
      PULSE: begin
        pend_set = stop;
        if (tmr_expire) begin
          state_d = LEAVE;
        end
      end
      LEAVE: begin
        idx_inc = 1'b1;
        if (stop || stop_pend || last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (gap_len(gap_s) == '0) begin
          state_d    = ARM;
          tmr_load   = 1'b1;
          tmr_ld_val = PRE_V;
        end else begin
          state_d    = GAP;
          tmr_load   = 1'b1;
          tmr_ld_val = gap_len(gap_s);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Shadow config captured on an accepted start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gap_s   <= '0;
      width_s <= '0;
      count_s <= '0;
      cont_s  <= 1'b0;
    end else if (accept) begin
      gap_s   <= cfg_gap;
      width_s <= cfg_width;
      count_s <= cfg_count;
      cont_s  <= mode_cont;
    end
  end

  // Stop seen mid-pulse is held until the pulse and leave finish.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stop_pend <= 1'b0;
    end else if (state_d == IDLE) begin
      stop_pend <= 1'b0;
    end else if (pend_set) begin
      stop_pend <= 1'b1;
    end
  end

  // Pulse index: cleared on start, bumped on every leave exit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pulse_idx <= '0;
    end else if (accept) begin
      pulse_idx <= '0;
    end else if (idx_inc) begin
      pulse_idx <= pulse_idx + NUM_W'(1);
    end
  end

  // Registered Moore decodes of the upcoming state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy           <= 1'b0;
      about_to_pulse <= 1'b0;
      comb_pulse     <= 1'b0;
      leaving        <= 1'b0;
      done           <= 1'b0;
    end else begin
      busy           <= (state_d != IDLE);
      about_to_pulse <= (state_d == ARM);
      comb_pulse     <= (state_d == PULSE);
      leaving        <= (state_d == LEAVE);
      done           <= done_d;
    end
  end

endmodule
